// File: rtl/xpb_window_accum.sv
// xpb_window_accum: walks the overflow segment of a square product one window
// per cycle, adding the matching xpb table word into a running sum seeded with
// the low segment. The result is left in redundant form with guard bits.
module xpb_window_accum #(
    parameter int DATA_W      = 1024,
    parameter int WINDOW_BITS = 5,
    parameter int NUM_WINDOWS = 8,
    parameter int GUARD_W     = 4,
    parameter int WIN_SEL_W   = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [DATA_W-1:0]                 lo_in,
    input  logic [NUM_WINDOWS*WINDOW_BITS-1:0] hi_in,
    output logic [WIN_SEL_W-1:0]              lut_window,
    output logic [WINDOW_BITS-1:0]            lut_idx,
    input  logic [DATA_W-1:0]                 lut_data,
    output logic                              busy,
    output logic                              done,
    output logic [DATA_W+GUARD_W-1:0]         result
);

    localparam int ACC_W = DATA_W + GUARD_W;
    localparam logic [WIN_SEL_W-1:0] LAST_WIN = WIN_SEL_W'(NUM_WINDOWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                           state_q, state_d;
    logic [ACC_W-1:0]                 acc_q, acc_d;
    logic [WIN_SEL_W-1:0]             cnt_q, cnt_d;
    logic [NUM_WINDOWS*WINDOW_BITS-1:0] hi_q, hi_d;

    // Latched overflow bits split into per-window slices for indexing by the counter.
    logic [WINDOW_BITS-1:0] win_arr [NUM_WINDOWS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WINDOWS; gi++) begin : g_win
            assign win_arr[gi] = hi_q[gi*WINDOW_BITS +: WINDOW_BITS];
        end
    endgenerate

    // Next-state logic: accept in IDLE/DONE, one table add per ACCUM cycle.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        case (state_q)
            ST_ACCUM: begin
                // A start here is deliberately ignored.
                acc_d = acc_q + {{GUARD_W{1'b0}}, lut_data};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_WIN) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (start) begin
                    hi_d    = hi_in;
                    acc_d   = {{GUARD_W{1'b0}}, lo_in};
                    cnt_d   = '0;
                    state_d = ST_ACCUM;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State registers with synchronous reset taking priority over start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
        end
    end

    // Table select/index come straight from the counter and latched hi; parked at 0 otherwise.
    always_comb begin
        lut_window = '0;
        lut_idx    = '0;
        if (state_q == ST_ACCUM) begin
            lut_window = cnt_q;
            lut_idx    = win_arr[cnt_q];
        end
    end

    assign busy   = (state_q == ST_ACCUM);
    assign done   = (state_q == ST_DONE);
    // The accumulator only changes on accept or in ACCUM, so it doubles as the held result.
    assign result = acc_q;

endmodule

// File: tb/tb_xpb_window_accum.sv
// Bench for xpb_window_accum: directed scenarios plus randomized operations,
// checked by a scoreboard queue drained by an independent done monitor.
module tb_xpb_window_accum;

    localparam int DW = 1024;
    localparam int WB = 5;
    localparam int NW = 8;
    localparam int GW = 4;
    localparam int WS = 3;
    localparam int AW = DW + GW;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [DW-1:0]     lo_in;
    logic [NW*WB-1:0]  hi_in;
    logic [WS-1:0]     lut_window;
    logic [WB-1:0]     lut_idx;
    logic [DW-1:0]     lut_data;
    logic              busy;
    logic              done;
    logic [AW-1:0]     result;

    bit                all_ones;
    int                checks = 0;
    int                errors = 0;
    int                txn    = 0;
    logic [AW-1:0]     exp_q[$];

    always #5 clk = ~clk;

    xpb_window_accum #(
        .DATA_W(DW), .WINDOW_BITS(WB), .NUM_WINDOWS(NW), .GUARD_W(GW), .WIN_SEL_W(WS)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .lo_in(lo_in), .hi_in(hi_in),
        .lut_window(lut_window), .lut_idx(lut_idx), .lut_data(lut_data),
        .busy(busy), .done(done), .result(result)
    );

    // Table model: 32*window + index, or all-ones for the max-magnitude case.
    always_comb begin
        if (all_ones) lut_data = '1;
        else          lut_data = DW'(32 * int'(lut_window) + int'(lut_idx));
    end

    function automatic logic [WB-1:0] win_of(input logic [NW*WB-1:0] hi, input int w);
        logic [NW*WB-1:0] sh;
        sh = hi >> (WB * w);
        return sh[WB-1:0];
    endfunction

    // Reference: lo plus the table word for every window, in a wide sum then truncated.
    function automatic logic [AW-1:0] model(input logic [DW-1:0] lo, input logic [NW*WB-1:0] hi,
                                            input bit ones);
        logic [AW+7:0] s;
        logic [DW-1:0] word;
        s = '0;
        s[DW-1:0] = lo;
        for (int w = 0; w < NW; w++) begin
            if (ones) word = '1;
            else      word = DW'(32 * w + int'(win_of(hi, w)));
            s = s + (AW+8)'(word);
        end
        return s[AW-1:0];
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic check(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h_%h exp=%h_%h", name, got[AW-1:AW-64], got[63:0],
                     exp[AW-1:AW-64], exp[63:0]);
        end
    endtask

    // Monitor: whenever done is seen, pop the oldest expectation and compare.
    initial begin
        logic [AW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done got=%h exp=no_done", result[63:0]);
                end else begin
                    e = exp_q.pop_front();
                    txn++;
                    check("result", result, e);
                    $display("txn %0d done result_lo=%h guard=%h", txn, result[63:0], result[AW-1:DW]);
                end
            end
        end
    end

    // Issue one operation from a negedge where the DUT is idle or in DONE; returns at the DONE negedge.
    task automatic run_op(input logic [DW-1:0] lo, input logic [NW*WB-1:0] hi, input bit ones,
                          input bit poke);
        start    = 1'b1;
        lo_in    = lo;
        hi_in    = hi;
        all_ones = ones;
        exp_q.push_back(model(lo, hi, ones));
        @(negedge clk);
        for (int w = 0; w < NW; w++) begin
            check("busy_accum", AW'(busy), AW'(1));
            check("lut_window", AW'(lut_window), AW'(w));
            check("lut_idx", AW'(lut_idx), AW'(win_of(hi, w)));
            if (poke && w == 3) begin
                start = 1'b1;
                lo_in = rand_word();
                hi_in = NW*WB'({$urandom(), $urandom()});
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_pulse", AW'(done), AW'(1));
        check("busy_in_done", AW'(busy), AW'(0));
        check("lut_window_done", AW'(lut_window), AW'(0));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; lo_in = '0; hi_in = '0; all_ones = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_busy", AW'(busy), AW'(0));
        check("rst_done", AW'(done), AW'(0));
        check("rst_result", result, AW'(0));
        check("rst_lut_window", AW'(lut_window), AW'(0));
        check("rst_lut_idx", AW'(lut_idx), AW'(0));

        // Zero overflow -> 901, then result holds while idle
        run_op(DW'(5), '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("hold_result", result, AW'(901));
        check("hold_busy", AW'(busy), AW'(0));
        check("hold_done", AW'(done), AW'(0));

        // All-ones overflow -> 1144
        run_op('0, 40'hFF_FFFF_FFFF, 1'b0, 1'b0);
        @(negedge clk);

        // Max magnitude: 9*(2^1024-1), guard MSB set
        run_op('1, NW*WB'({$urandom(), $urandom()}), 1'b1, 1'b0);
        check("max_guard_msb", AW'(result[AW-1]), AW'(1));
        @(negedge clk);
        all_ones = 1'b0;

        // Reset during the third ACCUM cycle, with start also high
        start = 1'b1; lo_in = DW'(7); hi_in = 40'h12_3456_789A;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("midrst_busy", AW'(busy), AW'(0));
        check("midrst_result", result, AW'(0));
        check("midrst_done", AW'(done), AW'(0));
        repeat (10) @(negedge clk);
        check("midrst_still_idle", AW'(busy), AW'(0));
        run_op(DW'(5), '0, 1'b0, 1'b0);
        @(negedge clk);

        // Start while busy ignored, then back-to-back start in DONE cycle -> 897
        run_op(DW'(5), '0, 1'b0, 1'b1);
        run_op(DW'(1), '0, 1'b0, 1'b0);
        @(negedge clk);

        // Randomized operations with random gaps, some back-to-back and some poked
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(rand_word(), NW*WB'({$urandom(), $urandom()}), (i % 7) == 3, (i % 5) == 0);
        end
        all_ones = 1'b0;
        repeat (4) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results got=%0d exp=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
